// File: rtl/br_pkg.sv
// Shared types and default sizing for the in-flight branch tracker.
package br_pkg;

  localparam int unsigned DEF_BR_DEPTH    = 4;
  localparam int unsigned DEF_ROB_TAG_LEN = 5;
  localparam int unsigned DEF_BR_TAG_W    = $clog2(DEF_BR_DEPTH);

  typedef logic [DEF_BR_TAG_W-1:0] br_tag_t;
  typedef logic [DEF_BR_DEPTH-1:0] br_mask_t;

  // older_mask records which live branches were already in flight at allocation
  typedef struct packed {
    logic                       valid;
    logic [DEF_ROB_TAG_LEN-1:0] rob_tag;
    br_mask_t                   older_mask;
  } br_entry_t;

  function automatic br_mask_t tag_onehot(br_tag_t tag);
    return br_mask_t'(1) << tag;
  endfunction

endpackage

// File: rtl/br_free_picker.sv
// Lowest-index free-slot priority encoder over a busy vector.
module br_free_picker
  import br_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_BR_DEPTH,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] busy,
  output logic [IDX_W-1:0] idx,
  output logic             none_free
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx       = '0;
    none_free = 1'b1;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx       = IDX_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/branch_tracker.sv
// Multi-branch tracker: tag allocation, correct-resolve clears and squash-mask recovery.
module branch_tracker
  import br_pkg::*;
#(
  parameter int unsigned BR_DEPTH    = DEF_BR_DEPTH,
  parameter int unsigned ROB_TAG_LEN = DEF_ROB_TAG_LEN,
  parameter int unsigned BR_TAG_W    = $clog2(BR_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   alloc_req,
  input  logic [ROB_TAG_LEN-1:0] alloc_rob_tag,
  output logic                   alloc_ack,
  output logic [BR_TAG_W-1:0]    alloc_tag,
  output logic [BR_DEPTH-1:0]    live_mask,
  output logic                   branch_full,
  input  logic                   res_valid,
  input  logic [BR_TAG_W-1:0]    res_tag,
  input  logic                   res_mispredict,
  output logic                   resolve,
  output logic [BR_DEPTH-1:0]    resolve_mask,
  output logic                   kill,
  output logic [BR_DEPTH-1:0]    kill_mask,
  output logic [ROB_TAG_LEN-1:0] kill_rob_tag
);

  logic [BR_DEPTH-1:0]    valid_q, valid_n;
  logic [BR_DEPTH-1:0]    older_q [BR_DEPTH];
  logic [BR_DEPTH-1:0]    older_n [BR_DEPTH];
  logic [ROB_TAG_LEN-1:0] rob_q   [BR_DEPTH];
  logic [ROB_TAG_LEN-1:0] rob_n   [BR_DEPTH];

  logic                   none_free_c;
  logic [BR_TAG_W-1:0]    free_tag_c;
  logic                   res_hit_c;
  logic                   res_ok_c;
  logic                   res_bad_c;
  logic [BR_DEPTH-1:0]    res_onehot_c;
  logic [BR_DEPTH-1:0]    squash_c;

  br_free_picker #(
    .WIDTH (BR_DEPTH),
    .IDX_W (BR_TAG_W)
  ) u_free_picker (
    .busy      (valid_q),
    .idx       (free_tag_c),
    .none_free (none_free_c)
  );

  // A mispredict drops any same-cycle allocation: that branch is younger and gets refetched.
  assign alloc_ack = alloc_req & ~none_free_c & ~(res_valid & res_mispredict);
  assign alloc_tag = free_tag_c;
  assign live_mask = valid_q;

  // Resolution decode and squash set: the mispredicted branch plus every live younger one.
  always_comb begin
    res_onehot_c = BR_DEPTH'(1) << res_tag;
    res_hit_c    = res_valid & valid_q[res_tag];
    res_ok_c     = res_hit_c & ~res_mispredict;
    res_bad_c    = res_hit_c & res_mispredict;
    squash_c     = res_onehot_c;
    for (int j = 0; j < int'(BR_DEPTH); j++) begin
      if (valid_q[j] && older_q[j][res_tag]) begin
        squash_c[j] = 1'b1;
      end
    end
  end

  // Entry array next state.
  always_comb begin
    valid_n = valid_q;
    older_n = older_q;
    rob_n   = rob_q;

    if (res_ok_c) begin
      valid_n = valid_n & ~res_onehot_c;
      for (int j = 0; j < int'(BR_DEPTH); j++) begin
        older_n[j] = older_n[j] & ~res_onehot_c;
      end
    end

    if (res_bad_c) begin
      valid_n = valid_n & ~squash_c;
      for (int j = 0; j < int'(BR_DEPTH); j++) begin
        older_n[j] = older_n[j] & ~squash_c;
      end
    end

    // Tag comes from registered state; a branch resolving this cycle is not its own elder.
    if (alloc_ack) begin
      valid_n[free_tag_c] = 1'b1;
      older_n[free_tag_c] = valid_q & ~({BR_DEPTH{res_ok_c}} & res_onehot_c);
      rob_n[free_tag_c]   = alloc_rob_tag;
    end
  end

  // State and registered broadcast outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q      <= '0;
      for (int i = 0; i < int'(BR_DEPTH); i++) begin
        older_q[i] <= '0;
        rob_q[i]   <= '0;
      end
      branch_full  <= 1'b0;
      resolve      <= 1'b0;
      resolve_mask <= '0;
      kill         <= 1'b0;
      kill_mask    <= '0;
      kill_rob_tag <= '0;
    end else begin
      valid_q      <= valid_n;
      for (int i = 0; i < int'(BR_DEPTH); i++) begin
        older_q[i] <= older_n[i];
        rob_q[i]   <= rob_n[i];
      end
      branch_full  <= &valid_n;
      resolve      <= res_ok_c;
      resolve_mask <= {BR_DEPTH{res_ok_c}} & res_onehot_c;
      kill         <= res_bad_c;
      kill_mask    <= {BR_DEPTH{res_bad_c}} & squash_c;
      kill_rob_tag <= res_bad_c ? rob_q[res_tag] : '0;
    end
  end

endmodule
